// File: rtl/wb_burst_reader_if.sv
// Wishbone read-initiator bus bundle for wb_burst_reader.
// The master drives the request side; the slave returns read data and ack.
interface wb_burst_reader_if;
  logic [23:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_we;
  logic [31:0] wb_dat_i;
  logic        wb_ack;

  modport master (
    output wb_adr, wb_sel, wb_cti, wb_stb, wb_cyc, wb_we,
    input  wb_dat_i, wb_ack
  );

  modport slave (
    input  wb_adr, wb_sel, wb_cti, wb_stb, wb_cyc, wb_we,
    output wb_dat_i, wb_ack
  );
endinterface

// File: rtl/wb_burst_reader.sv
// Streams word_count words from base_adr over Wishbone into a first-word
// fall-through FIFO, using 2-beat incrementing bursts when word-pair aligned.
//
// state    | meaning
// S_IDLE   | no job; start latches address/count, abort flushes the FIFO
// S_REQ    | waits for >=2 free slots, then holds cyc/stb until the first ack
// S_BURST2 | second beat of an incrementing burst (cti=111), held until ack
// S_GAP    | one bus-idle cycle; finish (done) or request the next transfer
module wb_burst_reader #(
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 16
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [21:0]        base_adr,
  input  logic [CNT_W-1:0]   word_count,
  output logic               busy,
  output logic               done,
  wb_burst_reader_if.master  wb,
  input  logic               rd_en,
  output logic [31:0]        rd_data,
  output logic               empty,
  output logic [FIFO_AW:0]   level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW+1:0] DEPTH_W = (FIFO_AW+2)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST2, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [21:0]        adr_q;
  logic [CNT_W-1:0]   rem_q;
  logic               abort_q;
  logic               in_cyc_q;
  logic               zero_done_q;

  logic               cyc;
  logic [2:0]         cti;
  logic               take;
  logic               flush;
  logic               done_c;
  logic               push;
  logic               pop;
  logic               burst_sel;
  logic               free_ok;
  logic               abort_p;
  logic [FIFO_AW+1:0] free_slots;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;

  assign pop        = rd_en && (count_q != '0);
  assign free_slots = DEPTH_W - {1'b0, count_q} + {{(FIFO_AW+1){1'b0}}, pop};
  assign free_ok    = free_slots >= (FIFO_AW+2)'(2);
  assign burst_sel  = !adr_q[0] && (rem_q >= CNT_W'(2));
  assign abort_p    = abort_q || abort;
  // Beats of an aborted job are still acked on the bus but never stored.
  assign push       = take && !abort_p;

  always_comb begin
    state_d = state_q;
    cyc     = 1'b0;
    cti     = 3'b000;
    take    = 1'b0;
    flush   = 1'b0;
    done_c  = zero_done_q;
    case (state_q)
      S_IDLE: begin
        if (abort) flush = 1'b1;
        if (start && (word_count != '0)) state_d = S_REQ;
      end
      S_REQ: begin
        // Once a cycle is on the bus it stays there until acked, abort or not.
        if (in_cyc_q || (free_ok && !abort_q)) begin
          cyc = 1'b1;
          cti = burst_sel ? 3'b010 : 3'b000;
          if (wb.wb_ack) begin
            take    = 1'b1;
            state_d = burst_sel ? S_BURST2 : S_GAP;
          end
        end else if (abort_q) begin
          state_d = S_GAP;
        end
      end
      S_BURST2: begin
        cyc = 1'b1;
        cti = 3'b111;
        if (wb.wb_ack) begin
          take    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if ((rem_q == '0) || abort_p) begin
          done_c  = 1'b1;
          flush   = abort_p;
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q     <= S_IDLE;
      adr_q       <= '0;
      rem_q       <= '0;
      abort_q     <= 1'b0;
      in_cyc_q    <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= (state_q == S_IDLE) && start && (word_count == '0);
      in_cyc_q    <= (state_q == S_REQ) && cyc && !wb.wb_ack;
      abort_q     <= (state_q != S_IDLE) && (state_d != S_IDLE) && abort_p;
      if ((state_q == S_IDLE) && start && (word_count != '0)) begin
        adr_q <= base_adr;
        rem_q <= word_count;
      end else if (take) begin
        adr_q <= adr_q + 22'd1;
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push) mem[wr_ptr_q] <= wb.wb_dat_i;
  end

  assign wb.wb_adr = {adr_q, 2'b00};
  assign wb.wb_sel = 4'hF;
  assign wb.wb_we  = 1'b0;
  assign wb.wb_cti = cti;
  assign wb.wb_stb = cyc;
  assign wb.wb_cyc = cyc;

  assign busy    = (state_q != S_IDLE);
  assign done    = done_c;
  assign rd_data = mem[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign level   = count_q;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed and randomized checks of wb_burst_reader against a transaction-level
// model: expected bus beats and FIFO words are derived from address/count only.
module tb_wb_burst_reader;
  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rd_en = 1'b0;
  logic [21:0] base_adr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, empty;
  logic [31:0] rd_data;
  logic [4:0]  level;

  wb_burst_reader_if bus();

  wb_burst_reader #(.FIFO_AW(4), .CNT_W(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .abort(abort),
    .base_adr(base_adr), .word_count(word_count), .busy(busy), .done(done),
    .wb(bus), .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .level(level)
  );

  always #5 wb_clk = ~wb_clk;

  int n_assert = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int stb_cnt = 0;
  int burst_lag = 0;
  bit spur_ack = 1'b0;
  int tx_snap, gap_snap, done_snap;

  logic [26:0] obs_tx[$];
  int          gaps_q[$];
  logic [26:0] exp_tx[$];
  logic [31:0] exp_data[$];

  function automatic logic [31:0] mem_word(logic [21:0] a);
    return {a[9:0], a} ^ 32'hC3A5_5A3C;
  endfunction

  // Slave: random initial wait, second burst beat burst_lag cycles after the first.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.wb_ack = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(posedge wb_clk);
      #1;
      if (bus.wb_cyc && bus.wb_stb) begin
        if (wait_cnt > 0) begin
          bus.wb_ack = 1'b0;
          wait_cnt--;
        end else begin
          bus.wb_ack = 1'b1;
          bus.wb_dat_i = mem_word(bus.wb_adr[23:2]);
          wait_cnt = (bus.wb_cti == 3'b010) ? burst_lag : 0;
        end
      end else begin
        bus.wb_ack = spur_ack;
        bus.wb_dat_i = 32'hDEAD_0000 ^ $urandom;
        wait_cnt = int'($urandom_range(0, 2));
      end
    end
  end

  initial begin
    int low_run;
    low_run = 0;
    forever begin
      @(negedge wb_clk);
      if (bus.wb_cyc && bus.wb_stb && bus.wb_ack) obs_tx.push_back({bus.wb_cti, bus.wb_adr});
      if (done) done_cnt++;
      if (bus.wb_stb) stb_cnt++;
      if (!busy) low_run = 0;
      else if (!bus.wb_cyc) low_run++;
      else begin
        if (low_run != 0) gaps_q.push_back(low_run);
        low_run = 0;
      end
    end
  end

  task automatic tick;
    @(negedge wb_clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build_model(logic [21:0] base, int count);
    logic [21:0] a;
    int r;
    exp_tx.delete();
    for (int i = 0; i < count; i++) exp_data.push_back(mem_word(base + 22'(i)));
    a = base;
    r = count;
    while (r > 0) begin
      if (!a[0] && r >= 2) begin
        exp_tx.push_back({3'b010, a, 2'b00});
        exp_tx.push_back({3'b111, a + 22'd1, 2'b00});
        a += 22'd2;
        r -= 2;
      end else begin
        exp_tx.push_back({3'b000, a, 2'b00});
        a += 22'd1;
        r -= 1;
      end
    end
  endtask

  task automatic start_job(logic [21:0] base, logic [15:0] cnt);
    tx_snap = obs_tx.size();
    gap_snap = gaps_q.size();
    done_snap = done_cnt;
    base_adr = base;
    word_count = cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int t;
    t = 0;
    while (done_cnt == done_snap && t < 3000) begin
      tick;
      t++;
    end
    tick;
    tick;
    chk({tag, "_done_pulses"}, 64'(done_cnt - done_snap), 64'd1);
  endtask

  task automatic verify_tx(string tag, bit gaps_on);
    int n, ncyc, bad;
    n = obs_tx.size() - tx_snap;
    chk({tag, "_tx_count"}, 64'(n), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < n; i++)
      chk({tag, "_tx"}, 64'(obs_tx[tx_snap + i]), 64'(exp_tx[i]));
    if (gaps_on) begin
      ncyc = 0;
      foreach (exp_tx[i]) if (exp_tx[i][26:24] != 3'b111) ncyc++;
      chk({tag, "_gap_count"}, 64'(gaps_q.size() - gap_snap), 64'(ncyc - 1));
      bad = 0;
      for (int i = gap_snap; i < gaps_q.size(); i++) if (gaps_q[i] != 1) bad = gaps_q[i];
      chk({tag, "_gap_len"}, 64'(bad), 64'd0);
    end
  endtask

  task automatic drain(string tag, int nwords);
    int t;
    logic [31:0] e;
    for (int k = 0; k < nwords; k++) begin
      t = 0;
      while (empty && t < 300) begin
        tick;
        t++;
      end
      chk({tag, "_avail"}, 64'(empty), 64'd0);
      if (!empty) begin
        e = (exp_data.size() != 0) ? exp_data.pop_front() : 32'h0;
        chk({tag, "_data"}, 64'(rd_data), 64'(e));
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
      end
    end
  endtask

  initial begin
    int t, snap, cnt;
    logic [21:0] b;

    tick;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cyc", 64'(bus.wb_cyc), 64'd0);
    chk("rst_stb", 64'(bus.wb_stb), 64'd0);
    chk("rst_cti", 64'(bus.wb_cti), 64'd0);
    chk("rst_adr", 64'(bus.wb_adr), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("sel_const", 64'(bus.wb_sel), 64'hF);
    chk("we_const", 64'(bus.wb_we), 64'd0);
    wb_rst = 1'b0;
    tick;
    tick;

    // Aligned 4-word job: two bursts.
    start_job(22'h000100, 16'd4);
    build_model(22'h000100, 4);
    wait_done("aligned4");
    verify_tx("aligned4", 1'b1);
    chk("aligned4_level", 64'(level), 64'd4);
    chk("aligned4_busy", 64'(busy), 64'd0);
    drain("aligned4", 4);

    // Misaligned start: classic, one idle cycle, then a burst.
    start_job(22'h000101, 16'd3);
    build_model(22'h000101, 3);
    wait_done("misal3");
    verify_tx("misal3", 1'b1);
    drain("misal3", 3);

    // Address wrap at the top of the 24-bit byte space.
    start_job(22'h3FFFFD, 16'd6);
    build_model(22'h3FFFFD, 6);
    wait_done("wrap6");
    verify_tx("wrap6", 1'b1);
    chk("wrap6_level", 64'(level), 64'd6);
    drain("wrap6", 6);

    for (int j = 0; j < 4; j++) begin
      b = 22'($urandom_range(0, 32'h3FFFFF));
      cnt = int'($urandom_range(1, 14));
      start_job(b, 16'(cnt));
      build_model(b, cnt);
      wait_done("rand");
      verify_tx("rand", 1'b1);
      chk("rand_level", 64'(level), 64'(cnt));
      drain("rand", cnt);
    end

    // 40 words with no consumer: must stall at a full FIFO with the bus idle.
    start_job(22'h000200, 16'd40);
    build_model(22'h000200, 40);
    t = 0;
    while (level != 5'd16 && t < 500) begin
      tick;
      t++;
    end
    repeat (5) tick;
    chk("stall_level", 64'(level), 64'd16);
    chk("stall_cyc", 64'(bus.wb_cyc), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    drain("stall", 2);
    t = 0;
    while (!bus.wb_cyc && t < 20) begin
      tick;
      t++;
    end
    chk("stall_resume", 64'(bus.wb_cyc), 64'd1);
    drain("stall", 38);
    wait_done("stall");
    verify_tx("stall", 1'b0);

    // Abort between burst beats; the late second beat is still taken.
    burst_lag = 2;
    start_job(22'h000300, 16'd8);
    build_model(22'h000300, 2);
    t = 0;
    while (obs_tx.size() == tx_snap && t < 200) begin
      tick;
      t++;
    end
    chk("abort_first_ack", 64'(obs_tx.size() > tx_snap), 64'd1);
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    wait_done("abort");
    verify_tx("abort", 1'b1);
    chk("abort_empty", 64'(empty), 64'd1);
    chk("abort_level", 64'(level), 64'd0);
    snap = stb_cnt;
    repeat (10) tick;
    chk("abort_no_stb", 64'(stb_cnt - snap), 64'd0);
    exp_data.delete();
    burst_lag = 0;

    // Zero-length job.
    snap = stb_cnt;
    base_adr = 22'h000040;
    word_count = 16'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    tick;
    chk("zero_done_end", 64'(done), 64'd0);
    chk("zero_no_stb", 64'(stb_cnt - snap), 64'd0);

    // A second start while busy is ignored.
    start_job(22'h000500, 16'd6);
    build_model(22'h000500, 6);
    tick;
    tick;
    base_adr = 22'h000007;
    word_count = 16'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done("busy_start");
    verify_tx("busy_start", 1'b1);
    chk("busy_start_level", 64'(level), 64'd6);
    drain("busy_start", 6);

    // Abort while idle flushes without a done pulse.
    start_job(22'h000020, 16'd3);
    build_model(22'h000020, 3);
    wait_done("idle_abort");
    chk("idle_abort_pre", 64'(level), 64'd3);
    snap = done_cnt;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
    chk("idle_abort_level", 64'(level), 64'd0);
    chk("idle_abort_empty", 64'(empty), 64'd1);
    chk("idle_abort_nodone", 64'(done_cnt - snap), 64'd0);
    exp_data.delete();

    // Ack with cyc low must not push.
    spur_ack = 1'b1;
    repeat (3) tick;
    spur_ack = 1'b0;
    tick;
    chk("spur_level", 64'(level), 64'd0);
    chk("spur_busy", 64'(busy), 64'd0);

    // Reset in the middle of a burst.
    burst_lag = 3;
    start_job(22'h000600, 16'd8);
    t = 0;
    while (obs_tx.size() == tx_snap && t < 200) begin
      tick;
      t++;
    end
    tick;
    wb_rst = 1'b1;
    #1;
    chk("mrst_cyc", 64'(bus.wb_cyc), 64'd0);
    chk("mrst_stb", 64'(bus.wb_stb), 64'd0);
    chk("mrst_level", 64'(level), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    tick;
    wb_rst = 1'b0;
    burst_lag = 0;
    tick;
    tick;
    exp_data.delete();
    start_job(22'h000010, 16'd5);
    build_model(22'h000010, 5);
    wait_done("post_rst");
    verify_tx("post_rst", 1'b1);
    chk("post_rst_level", 64'(level), 64'd5);
    drain("post_rst", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
